// File: rtl/chan_mux_pkg.sv
// Shared definitions for the round-robin channel multiplexer.
// Holds the mode encodings and the legal parameter limits.
// Optional feature macro used by the top: CHAN_MUX_PARITY_EN.
package chan_mux_pkg;

    // Selection mode driven on the 'mode' input of chan_mux_rr.
    typedef enum logic {
        MODE_FIXED = 1'b0,   // channel chosen by 'sel'
        MODE_RR    = 1'b1    // round-robin over valid channels
    } mode_e;

    // Upper limits of the supported configuration space.
    localparam int W_MAX = 64;
    localparam int N_MAX = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Scans the request vector upward starting one past last_grant, wrapping
// N-1 -> 0, and returns a one-hot grant (all zero when nothing requests).
module rr_arbiter
    import chan_mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] last_grant,
    output logic [N-1:0]  grant
);

    // cand_idx[gi] is the channel examined at scan position gi:
    // (last_grant + 1 + gi) mod N. last_grant is always a legal index, so
    // the sum never exceeds 2N-1 and a single conditional subtract wraps it.
    logic [CW-1:0] cand_idx [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            logic [CW:0] sum;
            assign sum = {1'b0, last_grant} + (CW+1)'(gi + 1);
            assign cand_idx[gi] = (sum >= (CW+1)'(N)) ? CW'(sum - (CW+1)'(N))
                                                      : CW'(sum);
        end
    endgenerate

    // First requesting candidate in scan order wins the grant.
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && (int'(cand_idx[i]) < N) && req[cand_idx[i]]) begin
                grant[cand_idx[i]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chan_mux_rr.sv
// N-channel to 1 multiplexer with a registered output stage.
// mode=0 takes the channel named by sel, mode=1 round-robins across the
// channels presenting valid data. The output register accepts a new word
// whenever it is empty or being drained, so it sustains one word per cycle.
// Optional feature: define CHAN_MUX_PARITY_EN to add out_parity, the XOR of
// out_data registered alongside it.
module chan_mux_rr
    import chan_mux_pkg::*;
#(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int CW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mode,
    input  logic [CW-1:0]  sel,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [CW-1:0]  out_chan,
`ifdef CHAN_MUX_PARITY_EN
    output logic           out_parity,
`endif
    input  logic           out_ready
);

    // Output register may take a new word when empty or being emptied.
    logic          load_en;
    // Round-robin pointer: channel granted most recently in mode=1.
    logic [CW-1:0] last_grant_reg;
    // One-hot candidate vectors for each selection mode.
    logic [N-1:0]  fixed_ready;
    logic [N-1:0]  rr_grant;
    // Channel actually transferring this cycle (one-hot or zero).
    logic [N-1:0]  hit;
    logic          accept;
    logic [CW-1:0] acc_chan;
    logic [W-1:0]  acc_word;

    assign load_en = !out_valid || out_ready;

    // Fixed path: decode sel to one-hot. An index >= N matches no bit, so
    // it produces no ready and therefore no load.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_fixed
            assign fixed_ready[gi] = (sel == CW'(gi));
        end
    endgenerate

    rr_arbiter #(
        .N  (N),
        .CW (CW)
    ) u_arb (
        .req        (in_valid),
        .last_grant (last_grant_reg),
        .grant      (rr_grant)
    );

    // Ready goes to the selected channel only while the output can load;
    // reset suppresses it so nothing is accepted during reset.
    always_comb begin
        in_ready = '0;
        if (!rst && load_en) begin
            if (mode == MODE_RR) begin
                in_ready = rr_grant;
            end else begin
                in_ready = fixed_ready;
            end
        end
    end

    assign hit    = in_ready & in_valid;
    assign accept = |hit;

    // AND-OR mux driven by the one-hot hit vector; keeps out-of-range
    // indices away from the data path and yields the winning channel index.
    always_comb begin
        acc_chan = '0;
        acc_word = '0;
        for (int k = 0; k < N; k++) begin
            if (hit[k]) begin
                acc_chan = acc_chan | CW'(k);
                acc_word = acc_word | in_data[k*W +: W];
            end
        end
    end

    // Output register and round-robin pointer. A new accept overwrites the
    // word being drained in the same cycle, so there is no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_chan       <= '0;
            last_grant_reg <= CW'(N - 1);
`ifdef CHAN_MUX_PARITY_EN
            out_parity     <= 1'b0;
`endif
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= acc_word;
            out_chan  <= acc_chan;
`ifdef CHAN_MUX_PARITY_EN
            out_parity <= ^acc_word;
`endif
            if (mode == MODE_RR) begin
                last_grant_reg <= acc_chan;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
